// File: rtl/flaf_pkg.sv
// Shared types and fixed-point helpers for the folded FLAF linear stage.
// All helper arithmetic is done in a wide signed type so intermediate sums never wrap.
package flaf_pkg;

   typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ERROR, S_UPDATE} state_t;

   localparam int CALC_W = 64;
   typedef logic signed [CALC_W-1:0] calc_t;

   function automatic int acc_w(input int width, input int n);
      return 2 * width + $clog2(n);
   endfunction

   function automatic calc_t sat(input calc_t value, input int width);
      calc_t hi;
      calc_t lo;
      hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
      lo = -(calc_t'(1) <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

   // Round-half-up arithmetic right shift; a zero shift passes the value through.
   function automatic calc_t rnd_shift(input calc_t value, input int sh);
      if (sh <= 0) return value;
      return (value + (calc_t'(1) <<< (sh - 1))) >>> sh;
   endfunction

endpackage

// File: rtl/flaf_mac.sv
// Single signed multiplier with a clearable accumulator; the product is also
// exposed directly so the weight update can use it as a plain multiplier.
module flaf_mac
   import flaf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ACC_W = 37
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic                    en_i,
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   output logic signed [2*WIDTH-1:0] prod_o,
   output logic signed [ACC_W-1:0]   acc_o
);

   logic signed [ACC_W-1:0] acc_q;

   assign prod_o = a_i * b_i;
   assign acc_o  = acc_q;

   // NOTE: clocked state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + ACC_W'(prod_o);
      end
   end

endmodule

// File: rtl/flaf_folded_lms.sv
// Folded LMS linear stage: one MAC walks L_ORD taps plus an optional bias tap,
// first to filter, then (when adapting) to update the weights in the same order.
module flaf_folded_lms
   import flaf_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int QP      = 12,
   parameter int L_ORD   = 32,
   parameter int BIAS    = 1,
   parameter int MU_SH_W = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x_in,
   input  logic [WIDTH-1:0]   d_in,
   input  logic               adapt_en,
   input  logic [MU_SH_W-1:0] mu_shift,
   output logic               out_valid,
   output logic [WIDTH-1:0]   y_out,
   output logic [WIDTH-1:0]   err_out
);

   localparam int N     = L_ORD + BIAS;
   localparam int ACC_W = acc_w(WIDTH, N);
   localparam int IDX_W = $clog2(L_ORD);
   localparam int K_W   = $clog2(N + 1);
   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << QP);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(L_ORD - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(N - 1);

   state_t                   state_q;
   logic signed [WIDTH-1:0]  buf_q [L_ORD];
   logic signed [WIDTH-1:0]  w_q [L_ORD];
   logic signed [WIDTH-1:0]  wb_q;
   logic [IDX_W-1:0]         wr_ptr_q, ptr_lat_q, rd_idx_q;
   logic [K_W-1:0]           k_q;
   logic signed [WIDTH-1:0]  d_q, mu_e_q, y_q, err_q;
   logic                     adapt_q, out_valid_q;
   logic [MU_SH_W-1:0]       mu_sh_q;

   logic                     accept, tap_bias;
   logic [IDX_W-1:0]         rd_idx_d, wr_ptr_d;
   logic signed [WIDTH-1:0]  x_sel, w_sel, mac_a;
   logic signed [WIDTH-1:0]  y_c, e_c, mu_e_c, upd_c;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]  acc;

   assign in_ready  = (state_q == S_IDLE) && !reset;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign y_out     = y_q;
   assign err_out   = err_q;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      tap_bias = 1'b0;
      mu_e_c   = '0;
      tap_bias = (int'(k_q) >= L_ORD);
      rd_idx_d = (rd_idx_q == '0) ? IDX_LAST : rd_idx_q - IDX_W'(1);
      wr_ptr_d = (wr_ptr_q == IDX_LAST) ? '0 : wr_ptr_q + IDX_W'(1);
      x_sel    = tap_bias ? ONE : buf_q[rd_idx_q];
      w_sel    = tap_bias ? wb_q : w_q[k_q[IDX_W-1:0]];
      mac_a    = (state_q == S_UPDATE) ? mu_e_q : w_sel;
      y_c      = WIDTH'(sat(rnd_shift(calc_t'(acc), QP), WIDTH));
      e_c      = WIDTH'(sat(calc_t'(d_q) - calc_t'(y_c), WIDTH));
      // Shifts past the sample width collapse to the sign, as a plain >>> would.
      if (int'(mu_sh_q) >= WIDTH) mu_e_c = (e_c < 0) ? '1 : '0;
      else                        mu_e_c = WIDTH'(rnd_shift(calc_t'(e_c), int'(mu_sh_q)));
      upd_c    = WIDTH'(sat(calc_t'(w_sel) + rnd_shift(calc_t'(prod), QP), WIDTH));
   end

   flaf_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
      .clk     (clk),
      .reset   (reset),
      .clear_i (accept),
      .en_i    (state_q == S_FILTER),
      .a_i     (mac_a),
      .b_i     (x_sel),
      .prod_o  (prod),
      .acc_o   (acc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: weights and sample buffer are small register arrays, so they are cleared on reset.
         for (int i = 0; i < L_ORD; i++) begin
            buf_q[i] <= '0;
            w_q[i]   <= '0;
         end
         state_q     <= S_IDLE;
         wb_q        <= '0;
         wr_ptr_q    <= '0;
         ptr_lat_q   <= '0;
         rd_idx_q    <= '0;
         k_q         <= '0;
         d_q         <= '0;
         mu_e_q      <= '0;
         y_q         <= '0;
         err_q       <= '0;
         adapt_q     <= 1'b0;
         mu_sh_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  buf_q[wr_ptr_q] <= $signed(x_in);
                  ptr_lat_q       <= wr_ptr_q;
                  rd_idx_q        <= wr_ptr_q;
                  wr_ptr_q        <= wr_ptr_d;
                  d_q             <= $signed(d_in);
                  adapt_q         <= adapt_en;
                  mu_sh_q         <= mu_shift;
                  k_q             <= '0;
                  state_q         <= S_FILTER;
               end
            end
            S_FILTER: begin
               k_q      <= k_q + K_W'(1);
               rd_idx_q <= rd_idx_d;
               if (k_q == K_LAST) begin
                  k_q      <= '0;
                  rd_idx_q <= ptr_lat_q;
                  state_q  <= S_ERROR;
               end
            end
            S_ERROR: begin
               y_q         <= y_c;
               err_q       <= e_c;
               mu_e_q      <= mu_e_c;
               out_valid_q <= 1'b1;
               state_q     <= adapt_q ? S_UPDATE : S_IDLE;
            end
            S_UPDATE: begin
               if (tap_bias) wb_q <= upd_c;
               else          w_q[k_q[IDX_W-1:0]] <= upd_c;
               k_q      <= k_q + K_W'(1);
               rd_idx_q <= rd_idx_d;
               if (k_q == K_LAST) begin
                  k_q      <= '0;
                  rd_idx_q <= ptr_lat_q;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flaf_folded_lms.sv
// Directed bench: dut_a (L_ORD=4) for reset/arithmetic/timing/saturation,
// dut_b (L_ORD=8) for buffer wrap and convergence.
module tb_flaf_folded_lms;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic        va, ra, ada, ova;
   logic [15:0] xa, da, ya, ea;
   logic [3:0]  mua;
   logic        vb, rb, adb, ovb;
   logic [15:0] xb, db, yb, eb;
   logic [3:0]  mub;

   flaf_folded_lms #(.WIDTH(16), .QP(12), .L_ORD(4), .BIAS(1), .MU_SH_W(4)) dut_a (
      .clk(clk), .reset(reset), .in_valid(va), .in_ready(ra), .x_in(xa), .d_in(da),
      .adapt_en(ada), .mu_shift(mua), .out_valid(ova), .y_out(ya), .err_out(ea));

   flaf_folded_lms #(.WIDTH(16), .QP(12), .L_ORD(8), .BIAS(1), .MU_SH_W(4)) dut_b (
      .clk(clk), .reset(reset), .in_valid(vb), .in_ready(rb), .x_in(xb), .d_in(db),
      .adapt_en(adb), .mu_shift(mub), .out_valid(ovb), .y_out(yb), .err_out(eb));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_assert++;
      assert (obs >= lo && obs <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected range [%0d,%0d]", tag, obs, lo, hi);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; va = 1'b0; vb = 1'b0;
      repeat (2) @(negedge clk);
      check("ready_in_reset", ra, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", ra, 1'b1);
      check("valid_after_reset", ova, 1'b0);
   endtask

   task automatic send_a(input logic [15:0] x, input logic [15:0] d, input logic ad,
                         input logic [3:0] mu, output logic [15:0] y, output logic [15:0] e);
      xa = x; da = d; ada = ad; mua = mu; va = 1'b1;
      for (int k = 0; k < 50 && !ra; k++) @(negedge clk);
      if (!ra) check("a_accept_timeout", ra, 1'b1);
      @(negedge clk);
      va = 1'b0;
      for (int k = 0; k < 50 && !ova; k++) @(negedge clk);
      if (!ova) check("a_out_valid_timeout", ova, 1'b1);
      y = ya; e = ea;
      for (int k = 0; k < 50 && !ra; k++) @(negedge clk);
      if (!ra) check("a_ready_timeout", ra, 1'b1);
   endtask

   task automatic send_b(input logic [15:0] x, input logic [15:0] d, input logic ad,
                         input logic [3:0] mu, output logic [15:0] y, output logic [15:0] e);
      xb = x; db = d; adb = ad; mub = mu; vb = 1'b1;
      for (int k = 0; k < 50 && !rb; k++) @(negedge clk);
      if (!rb) check("b_accept_timeout", rb, 1'b1);
      @(negedge clk);
      vb = 1'b0;
      for (int k = 0; k < 50 && !ovb; k++) @(negedge clk);
      if (!ovb) check("b_out_valid_timeout", ovb, 1'b1);
      y = yb; e = eb;
      for (int k = 0; k < 50 && !rb; k++) @(negedge clk);
      if (!rb) check("b_ready_timeout", rb, 1'b1);
   endtask

   // Called at a negedge where an accept is pending; counts cycles to out_valid and ready.
   task automatic measure(output int t_ov, output int t_rdy, output int n_ov);
      t_ov = -1; t_rdy = -1; n_ov = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ova) begin
            n_ov++;
            if (t_ov < 0) t_ov = k;
         end
         if (ra) begin
            t_rdy = k;
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] y, e, x, prev;
      logic [15:0] lfsr;
      int t_ov, t_rdy, n_ov, wb;

      reset = 1'b1;
      va = 1'b0; xa = '0; da = '0; ada = 1'b0; mua = '0;
      vb = 1'b0; xb = '0; db = '0; adb = 1'b0; mub = '0;

      // Reset release and frozen first sample
      repeat (3) @(negedge clk);
      check("ready_held_in_reset", ra, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("reset_ready", ra, 1'b1);
      check("reset_out_valid", ova, 1'b0);
      check("reset_y", ya, 16'h0000);
      check("reset_err", ea, 16'h0000);
      send_a(16'h1000, 16'h0800, 1'b0, 4'd0, y, e);
      check("t1_y", y, 16'h0000);
      check("t1_err", e, 16'h0800);

      // One adaptation step, then read back through the bias tap
      do_reset();
      send_a(16'h1000, 16'h1000, 1'b1, 4'd2, y, e);
      check("t2_y", y, 16'h0000);
      check("t2_err", e, 16'h1000);
      send_a(16'h0000, 16'h0000, 1'b0, 4'd0, y, e);
      check("t2_y_after", y, 16'h0400);
      check("t2_err_after", e, 16'hFC00);

      // Timing with in_valid held high
      do_reset();
      xa = '0; da = '0; ada = 1'b1; mua = 4'd2; va = 1'b1;
      measure(t_ov, t_rdy, n_ov);
      check("t3_adapt_ov_lat", t_ov, 32'd7);
      check("t3_adapt_rdy_lat", t_rdy, 32'd12);
      check("t3_adapt_ov_count", n_ov, 32'd1);
      ada = 1'b0;
      measure(t_ov, t_rdy, n_ov);
      check("t3_frozen_ov_lat", t_ov, 32'd7);
      check("t3_frozen_rdy_lat", t_rdy, 32'd7);
      check("t3_frozen_ov_count", n_ov, 32'd1);
      va = 1'b0;

      // Train bias to -0x4000, then demand a large positive error
      do_reset();
      send_a(16'h0000, 16'hC000, 1'b1, 4'd0, y, e);
      check("t4_train_err", e, 16'hC000);
      send_a(16'h0000, 16'h7FFF, 1'b0, 4'd0, y, e);
      check("t4_y", y, 16'hC000);
      check("t4_err_sat", e, 16'h7FFF);

      // Reset during UPDATE must discard the partly updated weights
      do_reset();
      xa = 16'h1000; da = 16'h1000; ada = 1'b1; mua = 4'd0; va = 1'b1;
      @(negedge clk);
      va = 1'b0;
      for (int k = 0; k < 50 && !ova; k++) @(negedge clk);
      if (!ova) check("t6_out_valid_timeout", ova, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6_ready_in_reset", ra, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t6_ready_after", ra, 1'b1);
      check("t6_valid_after", ova, 1'b0);
      send_a(16'h1000, 16'h0000, 1'b0, 4'd0, y, e);
      check("t6_y", y, 16'h0000);
      check("t6_err", e, 16'h0000);

      // Convergence on dut_b: d is x delayed by one sample
      do_reset();
      lfsr = 16'hACE1;
      prev = 16'h0000;
      for (int n = 0; n < 3000; n++) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         x = lfsr[0] ? 16'h0800 : 16'hF800;
         send_b(x, prev, 1'b1, 4'd3, y, e);
         prev = x;
      end
      check_range("t5_final_err", int'($signed(e)), -31, 31);
      for (int n = 0; n < 8; n++) send_b(16'h0000, 16'h0000, 1'b0, 4'd3, y, e);
      wb = int'($signed(y));
      check_range("t5_bias", wb, -63, 63);
      for (int j = 0; j < 8; j++) begin
         send_b((j == 0) ? 16'h1000 : 16'h0000, 16'h0000, 1'b0, 4'd3, y, e);
         if (j == 1) check_range("t5_w1", int'($signed(y)) - wb, 32'h1000 - 64, 32'h1000 + 64);
         else        check_range($sformatf("t5_w%0d", j), int'($signed(y)) - wb, -63, 63);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
